// File: rtl/idu_pkg.sv
// Shared definitions for the RV32I decode stage.
//   - Opcode constants and INST_WIDTH
//   - Control enums: ALU op, jump type, operand selects, immediate format,
//     jump/reg data select
//   - ram_byt and reg_wr_src codes
//   - Helpers mapping funct3 to ALU/jump types
package idu_pkg;

   localparam int unsigned INST_WIDTH = 32;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [4:0] {
      AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd,
      AluBeq, AluBne, AluBlt, AluBge, AluBltu, AluBgeu
   } alu_type_t;

   typedef enum logic [3:0] {
      JmpNone, JmpJal, JmpJalr, JmpBeq, JmpBne, JmpBlt, JmpBge, JmpBltu, JmpBgeu
   } jmp_type_t;

   typedef enum logic [1:0] {Rs1Reg = 2'd0, Rs1Pc = 2'd1, Rs1Zero = 2'd2} rs1_sel_t;
   typedef enum logic [1:0] {Rs2Reg = 2'd0, Rs2Imm = 2'd1, Rs2Four = 2'd2} rs2_sel_t;

   typedef enum logic [2:0] {ImmI, ImmS, ImmB, ImmU, ImmJ} imm_fmt_t;

   // Source of o_idu_jmp_or_reg_data
   typedef enum logic [1:0] {JdZero, JdPcImm, JdRegImm, JdRs2} jd_sel_t;

   localparam logic [2:0] RAM_BYT_B  = 3'd0;
   localparam logic [2:0] RAM_BYT_H  = 3'd1;
   localparam logic [2:0] RAM_BYT_W  = 3'd2;
   localparam logic [2:0] RAM_BYT_BU = 3'd4;
   localparam logic [2:0] RAM_BYT_HU = 3'd5;

   localparam logic [1:0] WR_SRC_ALU = 2'd0;
   localparam logic [1:0] WR_SRC_MEM = 2'd1;
   localparam logic [1:0] WR_SRC_PC4 = 2'd2;

   // alt is funct7[5]; callers must pass 0 where it does not select SUB/SRA
   function automatic alu_type_t alu_from_funct3(logic [2:0] f3, logic alt);
      case (f3)
         3'd0:    return alt ? AluSub : AluAdd;
         3'd1:    return AluSll;
         3'd2:    return AluSlt;
         3'd3:    return AluSltu;
         3'd4:    return AluXor;
         3'd5:    return alt ? AluSra : AluSrl;
         3'd6:    return AluOr;
         default: return AluAnd;
      endcase
   endfunction

   function automatic jmp_type_t branch_jmp(logic [2:0] f3);
      case (f3)
         3'd0:    return JmpBeq;
         3'd1:    return JmpBne;
         3'd4:    return JmpBlt;
         3'd5:    return JmpBge;
         3'd6:    return JmpBltu;
         3'd7:    return JmpBgeu;
         default: return JmpNone;
      endcase
   endfunction

   function automatic alu_type_t branch_alu(logic [2:0] f3);
      case (f3)
         3'd1:    return AluBne;
         3'd4:    return AluBlt;
         3'd5:    return AluBge;
         3'd6:    return AluBltu;
         3'd7:    return AluBgeu;
         default: return AluBeq;
      endcase
   endfunction

endpackage

// File: rtl/rv_idu_if.sv
// Bus between fetch/GPR file/execute and the decode stage.
//   master: drives instruction, PC, GPR data and ready; receives decode results
//   slave : the decode stage itself
// Optional: IDU_ILLEGAL_INST_EN adds o_idu_illegal.
interface rv_idu_if #(
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic                             i_sys_ready;
   logic                             o_sys_valid;
   logic [idu_pkg::INST_WIDTH-1:0]   i_ram_inst;
   logic [4:0]                       o_idu_ctr_alu_type;
   logic [1:0]                       o_idu_ctr_alu_rs1;
   logic [1:0]                       o_idu_ctr_alu_rs2;
   logic [3:0]                       o_idu_ctr_jmp_type;
   logic                             o_idu_ctr_ram_wr_en;
   logic [2:0]                       o_idu_ctr_ram_byt;
   logic                             o_idu_ctr_reg_wr_en;
   logic [1:0]                       o_idu_ctr_reg_wr_src;
   logic [DATA_WIDTH-1:0]            i_gpr_rs1_data;
   logic [DATA_WIDTH-1:0]            i_gpr_rs2_data;
   logic [4:0]                       o_idu_gpr_rs1_id;
   logic [4:0]                       o_idu_gpr_rs2_id;
   logic [4:0]                       o_idu_gpr_rd_id;
   logic [DATA_WIDTH-1:0]            i_ifu_pc;
   logic [DATA_WIDTH-1:0]            o_idu_rs1_data;
   logic [DATA_WIDTH-1:0]            o_idu_rs2_data;
   logic [DATA_WIDTH-1:0]            o_idu_jmp_or_reg_data;
`ifdef IDU_ILLEGAL_INST_EN
   logic                             o_idu_illegal;
`endif

   modport master (
      output i_sys_ready, i_ram_inst, i_gpr_rs1_data, i_gpr_rs2_data, i_ifu_pc,
      input  o_sys_valid, o_idu_ctr_alu_type, o_idu_ctr_alu_rs1, o_idu_ctr_alu_rs2,
             o_idu_ctr_jmp_type, o_idu_ctr_ram_wr_en, o_idu_ctr_ram_byt,
             o_idu_ctr_reg_wr_en, o_idu_ctr_reg_wr_src, o_idu_gpr_rs1_id,
             o_idu_gpr_rs2_id, o_idu_gpr_rd_id, o_idu_rs1_data, o_idu_rs2_data,
`ifdef IDU_ILLEGAL_INST_EN
             o_idu_illegal,
`endif
             o_idu_jmp_or_reg_data
   );

   modport slave (
      input  i_sys_ready, i_ram_inst, i_gpr_rs1_data, i_gpr_rs2_data, i_ifu_pc,
      output o_sys_valid, o_idu_ctr_alu_type, o_idu_ctr_alu_rs1, o_idu_ctr_alu_rs2,
             o_idu_ctr_jmp_type, o_idu_ctr_ram_wr_en, o_idu_ctr_ram_byt,
             o_idu_ctr_reg_wr_en, o_idu_ctr_reg_wr_src, o_idu_gpr_rs1_id,
             o_idu_gpr_rs2_id, o_idu_gpr_rd_id, o_idu_rs1_data, o_idu_rs2_data,
`ifdef IDU_ILLEGAL_INST_EN
             o_idu_illegal,
`endif
             o_idu_jmp_or_reg_data
   );

endinterface

// File: rtl/idu_imm_gen.sv
// Immediate generator: instruction word + format -> 32-bit sign-extended immediate.
//   inst : instruction word
//   fmt  : I/S/B/U/J format select
//   imm  : immediate (U-format is inst[31:12] << 12)
module idu_imm_gen
   import idu_pkg::*;
(
   input  logic [INST_WIDTH-1:0] inst,
   input  imm_fmt_t              fmt,
   output logic [31:0]           imm
);

   // Opcode bits never carry immediate data
   logic unused_opcode;
   assign unused_opcode = ^inst[6:0];

   always_comb begin
      imm = '0;
      case (fmt)
         ImmI:    imm = {{20{inst[31]}}, inst[31:20]};
         ImmS:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         ImmB:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         ImmU:    imm = {inst[31:12], 12'b0};
         ImmJ:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/rv_idu.sv
// RV32I instruction decode stage. Combinational decode; only o_sys_valid is registered.
//   i_sys_clk : clock
//   i_sys_rst : synchronous active-high reset (clears o_sys_valid only)
//   bus       : rv_idu_if slave - instruction/PC/GPR data in, decoded control and
//               selected operands out, ready/valid handshake
// Optional: define IDU_ILLEGAL_INST_EN to add bus.o_idu_illegal.
module rv_idu
   import idu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic     i_sys_clk,
   input logic     i_sys_rst,
   rv_idu_if.slave bus
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   assign opcode = bus.i_ram_inst[6:0];
   assign funct3 = bus.i_ram_inst[14:12];
   assign funct7 = bus.i_ram_inst[31:25];

   // Handshake register
   logic valid_q;
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) valid_q <= 1'b0;
      else           valid_q <= bus.i_sys_ready;
   end
   assign bus.o_sys_valid = valid_q;

   // Raw decode
   logic      legal, active;
   alu_type_t alu_type;
   rs1_sel_t  rs1_sel;
   rs2_sel_t  rs2_sel;
   jmp_type_t jmp_type;
   logic      ram_wr_en, reg_wr;
   logic [2:0] ram_byt;
   logic [1:0] wr_src;
   imm_fmt_t  imm_fmt;
   jd_sel_t   jd_sel;

   always_comb begin
      legal     = 1'b0;
      active    = 1'b0;
      alu_type  = AluAdd;
      rs1_sel   = Rs1Reg;
      rs2_sel   = Rs2Reg;
      jmp_type  = JmpNone;
      ram_wr_en = 1'b0;
      ram_byt   = RAM_BYT_B;
      reg_wr    = 1'b0;
      wr_src    = WR_SRC_ALU;
      imm_fmt   = ImmI;
      jd_sel    = JdZero;
      case (opcode)
         OPC_LUI: begin
            legal = 1'b1; active = 1'b1;
            rs1_sel = Rs1Zero; rs2_sel = Rs2Imm; imm_fmt = ImmU; reg_wr = 1'b1;
         end
         OPC_AUIPC: begin
            legal = 1'b1; active = 1'b1;
            rs1_sel = Rs1Pc; rs2_sel = Rs2Imm; imm_fmt = ImmU; reg_wr = 1'b1;
         end
         OPC_JAL: begin
            legal = 1'b1; active = 1'b1;
            rs1_sel = Rs1Pc; rs2_sel = Rs2Four; reg_wr = 1'b1; wr_src = WR_SRC_PC4;
            jmp_type = JmpJal; imm_fmt = ImmJ; jd_sel = JdPcImm;
         end
         OPC_JALR: begin
            legal = (funct3 == 3'd0); active = 1'b1;
            rs1_sel = Rs1Pc; rs2_sel = Rs2Four; reg_wr = 1'b1; wr_src = WR_SRC_PC4;
            jmp_type = JmpJalr; imm_fmt = ImmI; jd_sel = JdRegImm;
         end
         OPC_BRANCH: begin
            legal = (funct3 != 3'd2) && (funct3 != 3'd3); active = 1'b1;
            alu_type = branch_alu(funct3); jmp_type = branch_jmp(funct3);
            imm_fmt = ImmB; jd_sel = JdPcImm;
         end
         OPC_LOAD: begin
            legal = (funct3 == RAM_BYT_B) || (funct3 == RAM_BYT_H) || (funct3 == RAM_BYT_W) ||
                    (funct3 == RAM_BYT_BU) || (funct3 == RAM_BYT_HU);
            active = 1'b1;
            rs2_sel = Rs2Imm; reg_wr = 1'b1; wr_src = WR_SRC_MEM; ram_byt = funct3;
         end
         OPC_STORE: begin
            legal = (funct3 <= RAM_BYT_W); active = 1'b1;
            rs2_sel = Rs2Imm; imm_fmt = ImmS; ram_wr_en = 1'b1; ram_byt = funct3;
            jd_sel = JdRs2;
         end
         OPC_OP_IMM: begin
            active = 1'b1;
            case (funct3)
               3'd1:    legal = (funct7 == 7'h00);
               3'd5:    legal = (funct7 == 7'h00) || (funct7 == 7'h20);
               default: legal = 1'b1;
            endcase
            // inst[30] only distinguishes SRAI; ADDI never becomes SUB
            alu_type = alu_from_funct3(funct3, (funct3 == 3'd5) && bus.i_ram_inst[30]);
            rs2_sel = Rs2Imm; reg_wr = 1'b1;
         end
         OPC_OP: begin
            active = 1'b1;
            legal = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
            alu_type = alu_from_funct3(funct3, funct7[5]);
            reg_wr = 1'b1;
         end
         OPC_FENCE: legal = 1'b1;
         // Only ECALL/EBREAK are accepted; CSR ops are outside RV32I
         OPC_SYSTEM: legal = (funct3 == 3'd0) && (bus.i_ram_inst[19:7] == '0) &&
                             (bus.i_ram_inst[31:21] == '0);
         default: legal = 1'b0;
      endcase
   end

   // Anything not both legal and an executing class collapses to a NOP
   logic exec;
   assign exec = legal && active;

   logic [31:0]           imm32;
   logic [DATA_WIDTH-1:0] imm;

   idu_imm_gen u_imm_gen (
      .inst (bus.i_ram_inst),
      .fmt  (imm_fmt),
      .imm  (imm32)
   );

   assign imm = DATA_WIDTH'($signed(imm32));

   assign bus.o_idu_gpr_rs1_id = bus.i_ram_inst[19:15];
   assign bus.o_idu_gpr_rs2_id = bus.i_ram_inst[24:20];
   assign bus.o_idu_gpr_rd_id  = bus.i_ram_inst[11:7];

   always_comb begin
      bus.o_idu_ctr_alu_type   = exec ? alu_type : AluAdd;
      bus.o_idu_ctr_alu_rs1    = exec ? rs1_sel : Rs1Reg;
      bus.o_idu_ctr_alu_rs2    = exec ? rs2_sel : Rs2Reg;
      bus.o_idu_ctr_jmp_type   = exec ? jmp_type : JmpNone;
      bus.o_idu_ctr_ram_wr_en  = exec && ram_wr_en;
      bus.o_idu_ctr_ram_byt    = exec ? ram_byt : RAM_BYT_B;
      bus.o_idu_ctr_reg_wr_en  = exec && reg_wr && (bus.i_ram_inst[11:7] != 5'd0);
      bus.o_idu_ctr_reg_wr_src = exec ? wr_src : WR_SRC_ALU;

      bus.o_idu_rs1_data = '0;
      bus.o_idu_rs2_data = '0;
      bus.o_idu_jmp_or_reg_data = '0;
      if (exec) begin
         case (rs1_sel)
            Rs1Reg:  bus.o_idu_rs1_data = bus.i_gpr_rs1_data;
            Rs1Pc:   bus.o_idu_rs1_data = bus.i_ifu_pc;
            default: bus.o_idu_rs1_data = '0;
         endcase
         case (rs2_sel)
            Rs2Reg:  bus.o_idu_rs2_data = bus.i_gpr_rs2_data;
            Rs2Imm:  bus.o_idu_rs2_data = imm;
            Rs2Four: bus.o_idu_rs2_data = DATA_WIDTH'(4);
            default: bus.o_idu_rs2_data = '0;
         endcase
         case (jd_sel)
            JdPcImm:  bus.o_idu_jmp_or_reg_data = bus.i_ifu_pc + imm;
            JdRegImm: bus.o_idu_jmp_or_reg_data = (bus.i_gpr_rs1_data + imm) & ~DATA_WIDTH'(1);
            JdRs2:    bus.o_idu_jmp_or_reg_data = bus.i_gpr_rs2_data;
            default:  bus.o_idu_jmp_or_reg_data = '0;
         endcase
      end
   end

`ifdef IDU_ILLEGAL_INST_EN
   assign bus.o_idu_illegal = !legal;
`endif

endmodule

// File: tb/tb_rv_idu.sv
// Bench for rv_idu: table of instruction vectors with expected decode, plus a
// handshake/reset sequence, both checked through an expected-result queue.
module tb_rv_idu;
   import idu_pkg::*;

   localparam logic [31:0] PC = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rv_idu_if #(.DATA_WIDTH(32)) bus ();

   rv_idu #(.DATA_WIDTH(32)) dut (
      .i_sys_clk (clk),
      .i_sys_rst (rst),
      .bus       (bus.slave)
   );

   typedef struct {
      logic [31:0] inst;
      logic [4:0]  alu;
      logic [1:0]  s1;
      logic [1:0]  s2;
      logic [3:0]  jmp;
      logic        ram_wr;
      logic [2:0]  byt;
      logic        reg_wr;
      logic [1:0]  src;
      logic [4:0]  rs1_id;
      logic [4:0]  rs2_id;
      logic [4:0]  rd_id;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] jd;
      logic        ill;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t vecs[$];
   vec_t exp_q[$];
   logic valid_q_exp[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(logic [31:0] inst, alu_type_t alu, logic [1:0] s1,
                               logic [1:0] s2, jmp_type_t jmp, logic ram_wr, logic [2:0] byt,
                               logic reg_wr, logic [1:0] src, logic [4:0] r1, logic [4:0] r2,
                               logic [4:0] rd, logic [31:0] op1, logic [31:0] op2,
                               logic [31:0] jd, logic ill);
      vec_t v;
      v.inst = inst; v.alu = alu; v.s1 = s1; v.s2 = s2; v.jmp = jmp; v.ram_wr = ram_wr;
      v.byt = byt; v.reg_wr = reg_wr; v.src = src; v.rs1_id = r1; v.rs2_id = r2;
      v.rd_id = rd; v.op1 = op1; v.op2 = op2; v.jd = jd; v.ill = ill;
      return v;
   endfunction

   task automatic check_decode(input vec_t e, input int idx);
      string t;
      t = $sformatf("v%0d_%h", idx, e.inst);
      chk({t, "_alu"},    32'(bus.o_idu_ctr_alu_type),   32'(e.alu));
      chk({t, "_s1"},     32'(bus.o_idu_ctr_alu_rs1),    32'(e.s1));
      chk({t, "_s2"},     32'(bus.o_idu_ctr_alu_rs2),    32'(e.s2));
      chk({t, "_jmp"},    32'(bus.o_idu_ctr_jmp_type),   32'(e.jmp));
      chk({t, "_ramwr"},  32'(bus.o_idu_ctr_ram_wr_en),  32'(e.ram_wr));
      chk({t, "_byt"},    32'(bus.o_idu_ctr_ram_byt),    32'(e.byt));
      chk({t, "_regwr"},  32'(bus.o_idu_ctr_reg_wr_en),  32'(e.reg_wr));
      chk({t, "_src"},    32'(bus.o_idu_ctr_reg_wr_src), 32'(e.src));
      chk({t, "_rs1id"},  32'(bus.o_idu_gpr_rs1_id),     32'(e.rs1_id));
      chk({t, "_rs2id"},  32'(bus.o_idu_gpr_rs2_id),     32'(e.rs2_id));
      chk({t, "_rdid"},   32'(bus.o_idu_gpr_rd_id),      32'(e.rd_id));
      chk({t, "_op1"},    bus.o_idu_rs1_data,            e.op1);
      chk({t, "_op2"},    bus.o_idu_rs2_data,            e.op2);
      chk({t, "_jd"},     bus.o_idu_jmp_or_reg_data,     e.jd);
`ifdef IDU_ILLEGAL_INST_EN
      chk({t, "_ill"},    32'(bus.o_idu_illegal),        32'(e.ill));
`endif
   endtask

   // Drive ready, queue the valid expected after the next edge, check at negedge
   task automatic valid_step(input logic r, input logic ready, input logic exp, input string name);
      rst = r;
      bus.i_sys_ready = ready;
      valid_q_exp.push_back(exp);
      @(negedge clk);
      chk(name, 32'(bus.o_sys_valid), 32'(valid_q_exp.pop_front()));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.i_sys_ready    = 1'b1;
      bus.i_ram_inst     = 32'h0;
      bus.i_gpr_rs1_data = 32'd1;
      bus.i_gpr_rs2_data = 32'd2;
      bus.i_ifu_pc       = PC;

      //        inst          alu     s1 s2 jmp      rw byt rg src r1  r2  rd  op1   op2            jd            ill
      vecs.push_back(mk(32'h0000A0B7, AluAdd, 2, 1, JmpNone, 0, 0, 1, 0, 1,  0,  1,  0,    32'h0000A000, 0,            0));
      vecs.push_back(mk(32'h0000A097, AluAdd, 1, 1, JmpNone, 0, 0, 1, 0, 1,  0,  1,  PC,   32'h0000A000, 0,            0));
      vecs.push_back(mk(32'h00A000EF, AluAdd, 1, 2, JmpJal,  0, 0, 1, 2, 0,  10, 1,  PC,   4,            32'h8000000A, 0));
      vecs.push_back(mk(32'h00A100E7, AluAdd, 1, 2, JmpJalr, 0, 0, 1, 2, 2,  10, 1,  PC,   4,            32'h0000000A, 0));
      vecs.push_back(mk(32'h00208563, AluBeq, 0, 0, JmpBeq,  0, 0, 0, 0, 1,  2,  10, 1,    2,            32'h8000000A, 0));
      vecs.push_back(mk(32'h00110023, AluAdd, 0, 1, JmpNone, 1, 0, 0, 0, 2,  1,  0,  1,    0,            2,            0));
      vecs.push_back(mk(32'h003100B3, AluAdd, 0, 0, JmpNone, 0, 0, 1, 0, 2,  3,  1,  1,    2,            0,            0));
      vecs.push_back(mk(32'h0FF0000F, AluAdd, 0, 0, JmpNone, 0, 0, 0, 0, 0,  31, 0,  0,    0,            0,            0));
      vecs.push_back(mk(32'h00000073, AluAdd, 0, 0, JmpNone, 0, 0, 0, 0, 0,  0,  0,  0,    0,            0,            0));
      vecs.push_back(mk(32'h00100073, AluAdd, 0, 0, JmpNone, 0, 0, 0, 0, 0,  1,  0,  0,    0,            0,            0));
      // sub x0,x1,x2: rd==x0 suppresses the write
      vecs.push_back(mk(32'h40208033, AluSub, 0, 0, JmpNone, 0, 0, 0, 0, 1,  2,  0,  1,    2,            0,            0));
      // srai x3,x1,4
      vecs.push_back(mk(32'h4040D193, AluSra, 0, 1, JmpNone, 0, 0, 1, 0, 1,  4,  3,  1,    32'h00000404, 0,            0));
      // lw x5,-4(x1): negative I immediate
      vecs.push_back(mk(32'hFFC0A283, AluAdd, 0, 1, JmpNone, 0, 2, 1, 1, 1,  28, 5,  1,    32'hFFFFFFFC, 0,            0));
      // lhu x5,0(x1)
      vecs.push_back(mk(32'h0000D283, AluAdd, 0, 1, JmpNone, 0, 5, 1, 1, 1,  0,  5,  1,    0,            0,            0));
      // inst[1:0]!=11 and an unknown opcode
      vecs.push_back(mk(32'h00000000, AluAdd, 0, 0, JmpNone, 0, 0, 0, 0, 0,  0,  0,  0,    0,            0,            1));
      vecs.push_back(mk(32'hFFFFFFFF, AluAdd, 0, 0, JmpNone, 0, 0, 0, 0, 31, 31, 31, 0,    0,            0,            1));
      // mul (funct7=1) is not RV32I
      vecs.push_back(mk(32'h022080B3, AluAdd, 0, 0, JmpNone, 0, 0, 0, 0, 1,  2,  1,  0,    0,            0,            1));

      // Reset held three cycles
      for (int i = 0; i < 3; i++) valid_step(1'b1, 1'b1, 1'b0, $sformatf("valid_rst%0d", i));
      valid_step(1'b0, 1'b1, 1'b1, "valid_ready1");
      valid_step(1'b0, 1'b0, 1'b0, "valid_ready0");
      valid_step(1'b0, 1'b1, 1'b1, "valid_ready1_again");
      // Mid-operation reset clears valid but decode stays live
      bus.i_ram_inst = 32'h0000A0B7;
      valid_step(1'b1, 1'b1, 1'b0, "valid_midrst");
      chk("decode_in_rst_op2", bus.o_idu_rs2_data, 32'h0000A000);
      valid_step(1'b0, 1'b1, 1'b1, "valid_after_rst");

      for (int i = 0; i < vecs.size(); i++) begin
         bus.i_ram_inst = vecs[i].inst;
         exp_q.push_back(vecs[i]);
         #1;
         check_decode(exp_q.pop_front(), i);
         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
